// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debouncer state encoding and parameter minimums
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW     = 2'b00,
      ST_WAIT_HI = 2'b01,
      ST_HIGH    = 2'b10,
      ST_WAIT_LO = 2'b11
   } deb_state_t;

   localparam int DEB_MIN_CYCLES = 2;
   localparam int DEB_MIN_SYNC   = 2;

endpackage

// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - debouncer signal bundle; pulse signals exist only with DEBOUNCE_EDGE_PULSE_EN
interface input_debouncer_if;

   logic raw_in;
   logic clean_out;
   logic busy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic rise_pulse;
   logic fall_pulse;

   modport master (output raw_in, input clean_out, input busy, input rise_pulse, input fall_pulse);
   modport slave  (input raw_in, output clean_out, output busy, output rise_pulse, output fall_pulse);
`else
   modport master (output raw_in, input clean_out, input busy);
   modport slave  (input raw_in, output clean_out, output busy);
`endif

endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - N-flop synchroniser for asynchronous level inputs, async active-high reset to 0
module sync_chain
   import debounce_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   if (STAGES < DEB_MIN_SYNC) begin : g_bad_stages
      $error("sync_chain: STAGES below minimum");
   end

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce a raw level input; DEBOUNCE_EDGE_PULSE_EN adds edge pulses
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input_debouncer_if.slave  deb
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < DEB_MIN_SYNC) begin : g_bad_sync
      $error("input_debouncer: SYNC_STAGES below minimum");
   end
   if (DEBOUNCE_CYCLES < DEB_MIN_CYCLES) begin : g_bad_cycles
      $error("input_debouncer: DEBOUNCE_CYCLES below minimum");
   end

   logic             s;
   deb_state_t       state;
   deb_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept_hi;
   logic             accept_lo;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (deb.raw_in),
      .q     (s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_LOW;
         cnt           <= '0;
         deb.clean_out <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept_hi) begin
            deb.clean_out <= 1'b1;
         end else if (accept_lo) begin
            deb.clean_out <= 1'b0;
         end
      end
   end

   // Any reversion during a WAIT state drops the partial count entirely.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept_hi = 1'b0;
      accept_lo = 1'b0;
      case (state)
         ST_LOW: begin
            if (s) begin
               state_nxt = ST_WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!s) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
               accept_hi = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_nxt = ST_WAIT_LO;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LO: begin
            if (s) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
               accept_lo = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      deb.busy = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
   end

`ifdef DEBOUNCE_EDGE_PULSE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb.rise_pulse <= 1'b0;
         deb.fall_pulse <= 1'b0;
      end else begin
         deb.rise_pulse <= accept_hi;
         deb.fall_pulse <= accept_lo;
      end
   end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer; honours DEBOUNCE_EDGE_PULSE_EN
module tb_input_debouncer;

   localparam int S = 2;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   input_debouncer_if dif ();

   input_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .reset (reset),
      .deb   (dif)
   );

   always #5 clk = ~clk;

   // Reference: s is raw delayed by S edges; clean flips once s has differed
   // from it on D+1 consecutive edges.
   logic [S-1:0] m_sh;
   int           m_run;
   logic         m_clean, m_rise, m_fall;
   logic         m_busy;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sh    <= '0;
         m_run   <= 0;
         m_clean <= 1'b0;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
      end else begin
         m_sh   <= {m_sh[S-2:0], dif.raw_in};
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         if (m_sh[S-1] == m_clean) begin
            m_run <= 0;
         end else if (m_run == D) begin
            m_run   <= 0;
            m_clean <= ~m_clean;
            m_rise  <= ~m_clean;
            m_fall  <= m_clean;
         end else begin
            m_run <= m_run + 1;
         end
      end
   end

   assign m_busy = (m_run != 0);

   task automatic chk(input string nm, input logic act, input logic exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   always @(posedge clk) begin
      #3;
      chk("model clean_out", dif.clean_out, m_clean);
      chk("model busy", dif.busy, m_busy);
`ifdef DEBOUNCE_EDGE_PULSE_EN
      chk("model rise_pulse", dif.rise_pulse, m_rise);
      chk("model fall_pulse", dif.fall_pulse, m_fall);
      chk("pulses exclusive", dif.rise_pulse & dif.fall_pulse, 1'b0);
`endif
   end

   // Bit i-1 of each mask is the value expected just after edge i.
   task automatic run_edges(input string nm, input int n, input logic [15:0] eb,
                            input logic [15:0] ec, input logic [15:0] er, input logic [15:0] ef);
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         chk({nm, " busy"}, dif.busy, eb[i-1]);
         chk({nm, " clean_out"}, dif.clean_out, ec[i-1]);
`ifdef DEBOUNCE_EDGE_PULSE_EN
         chk({nm, " rise_pulse"}, dif.rise_pulse, er[i-1]);
         chk({nm, " fall_pulse"}, dif.fall_pulse, ef[i-1]);
`else
         if (er[i-1] === 1'bx || ef[i-1] === 1'bx) chk({nm, " mask"}, 1'b0, 1'b1);
`endif
      end
   endtask

   task automatic drive(input logic v);
      @(negedge clk);
      dif.raw_in = v;
   endtask

   initial begin
      // 1: reset with raw_in held high
      dif.raw_in = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset clean_out", dif.clean_out, 1'b0);
         chk("reset busy", dif.busy, 1'b0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
         chk("reset rise_pulse", dif.rise_pulse, 1'b0);
         chk("reset fall_pulse", dif.fall_pulse, 1'b0);
`endif
      end
      @(negedge clk);
      reset = 1'b0;
      run_edges("t1", 9, 16'h003C, 16'h01C0, 16'h0040, 16'h0000);

      // 4: bounce 1,0,1,0 then hold 0 from clean high
      drive(1'b1);
      @(posedge clk);
      drive(1'b0);
      @(posedge clk);
      drive(1'b1);
      @(posedge clk);
      drive(1'b0);
      run_edges("t4", 9, 16'h003D, 16'h003F, 16'h0000, 16'h0040);

      // 3: three-cycle glitch is rejected
      repeat (3) @(posedge clk);
      drive(1'b1);
      run_edges("t3a", 3, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
      drive(1'b0);
      run_edges("t3b", 5, 16'h0003, 16'h0000, 16'h0000, 16'h0000);

      // 2: clean step
      repeat (3) @(posedge clk);
      drive(1'b1);
      run_edges("t2", 9, 16'h003C, 16'h01C0, 16'h0040, 16'h0000);

      // 5: async reset in WAIT_HI with cnt=2, from clean low
      drive(1'b0);
      repeat (10) @(posedge clk);
      drive(1'b1);
      run_edges("t5 pre", 5, 16'h001C, 16'h0000, 16'h0000, 16'h0000);
      chk("t5 cnt before reset", dut.cnt == 2'd2, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      chk("t5 async busy", dif.busy, 1'b0);
      chk("t5 async clean_out", dif.clean_out, 1'b0);
      chk("t5 async cnt", dut.cnt == 2'd0, 1'b1);
      @(negedge clk);
      dif.raw_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run_edges("t5 post", 10, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
